// File: rtl/wb_dsp_arbiter_pkg.sv
// Shared types for the DSP Wishbone arbiter: FSM states, one-hot grant codes,
// default watchdog limit and a state-to-grant helper.
package wb_dsp_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    function automatic logic [1:0] state_to_gnt(arb_state_e st);
        case (st)
            ST_GNT0: return GNT_M0;
            ST_GNT1: return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts inc cycles, clears on clr, registers a one-cycle fire
// pulse after LIMIT consecutive inc cycles. LIMIT=0 disables it.
module wb_arb_watchdog #(
    parameter int LIMIT = 256,
    parameter int TCW   = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic fire_o
);

    localparam logic [TCW-1:0] LAST = TCW'((LIMIT > 0) ? (LIMIT - 1) : 0);

    logic [TCW-1:0] cnt_q, cnt_d;
    logic           fire_q, fire_d;

    always_comb begin
        cnt_d  = cnt_q;
        fire_d = 1'b0;
        if (clr_i || (LIMIT == 0)) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                fire_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fire_q <= fire_d;
        end
    end

    assign fire_o = fire_q;

endmodule

// File: rtl/wb_dsp_arbiter.sv
// Two-master Wishbone classic arbiter for the DSP slave bus (m0 = DAQ, m1 = CPU).
// Registered grant held while the owner keeps cyc; slave-side mux is combinational.
module wb_dsp_arbiter
    import wb_dsp_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TCW            = 16
) (
    input  logic            wb_clk,
    input  logic            wb_rst,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_m1_q, last_m1_d;
    logic       stall, wd_fire, wd_err;

    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        case (state_q)
            ST_IDLE: begin
                // Ties go to m0 in priority mode, otherwise to whoever did not own last.
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = ((PRIORITY_MODE != 0) || last_m1_q) ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                end
                if (state_d == ST_GNT0) begin
                    last_m1_d = 1'b0;
                end else if (state_d == ST_GNT1) begin
                    last_m1_d = 1'b1;
                end
            end
            ST_GNT0: if (!m0_cyc_i) state_d = ST_IDLE;
            ST_GNT1: if (!m1_cyc_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        case (state_q)
            ST_GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_sel_o = m0_sel_i;
                s_dat_o = m0_dat_i;
            end
            ST_GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_sel_o = m1_sel_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // A slave termination in the firing cycle wins over the watchdog.
    assign stall  = s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
    assign wd_err = wd_fire && (state_q != ST_IDLE) && !s_ack_i && !s_err_i;

    wb_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .TCW   (TCW)
    ) u_watchdog (
        .clk_i  (wb_clk),
        .rst_i  (wb_rst),
        .inc_i  (stall),
        .clr_i  (!stall),
        .fire_o (wd_fire)
    );

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign m0_ack_o  = (state_q == ST_GNT0) && s_ack_i;
    assign m1_ack_o  = (state_q == ST_GNT1) && s_ack_i;
    assign m0_err_o  = (state_q == ST_GNT0) && (s_err_i || wd_err);
    assign m1_err_o  = (state_q == ST_GNT1) && (s_err_i || wd_err);
    assign gnt_o     = state_to_gnt(state_q);
    assign timeout_o = wd_err;

endmodule
